fb_pattern_writer: RTL and testbench

Wishbone master that fills the SDRAM framebuffer with a test pattern, one 32-bit pixel per write, in the same raster order and byte addressing that the VGA controller reads back. It sits on the Wishbone bus alongside the VGA reader, upstream of it. It writes in bursts separated by idle gaps so the reader's FIFO refill is never starved. One frame is written per `start` pulse, or continuously when `loop` is high.

---
 rtl/fb_pattern_writer_if.sv | 22 ++
 rtl/fb_pattern_writer.sv | 236 +++++++++++++++++++++++
 tb/tb_fb_pattern_writer.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fb_pattern_writer_if.sv
// Wishbone write-master bus between the pattern writer and the SDRAM arbiter.
interface fb_pattern_writer_if;
    logic [31:0] adr;
    logic [31:0] dat_ms;
    logic        we;
    logic [3:0]  sel;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        stb;
    logic        cyc;
    logic        ack;

    modport master (
        output adr, dat_ms, we, sel, cti, bte, stb, cyc,
        input  ack
    );

    modport slave (
        input  adr, dat_ms, we, sel, cti, bte, stb, cyc,
        output ack
    );
endinterface

// File: rtl/fb_pattern_writer.sv
// Wishbone master that fills the framebuffer with a test pattern in raster
// order, one pixel per write, in bursts of BURST separated by PAUSE idle cycles.
module fb_pattern_writer #(
    parameter int unsigned HDISP = 800,
    parameter int unsigned VDISP = 480,
    parameter int unsigned BURST = 64,
    parameter int unsigned PAUSE = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                loop,
    input  logic [1:0]          mode,
    input  logic [23:0]         color,
    output logic                busy,
    output logic                frame_done,
    fb_pattern_writer_if.master wb
);

    // x/y are at least 8/4 bits wide so the pattern bit-slices always exist
    localparam int unsigned XW    = ($clog2(HDISP) < 8) ? 8 : $clog2(HDISP);
    localparam int unsigned YW    = ($clog2(VDISP) < 4) ? 4 : $clog2(VDISP);
    localparam int unsigned BCW   = $clog2(BURST + 1);
    localparam int unsigned PCW   = $clog2(PAUSE + 1);
    localparam int unsigned BARW  = ((HDISP / 8) < 1) ? 1 : (HDISP / 8);
    localparam int unsigned BNCW  = $clog2(BARW + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_PAUSE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [2:0]        bar_q, bar_d;
    logic [BNCW-1:0]   bar_cnt_q, bar_cnt_d;
    logic [BCW-1:0]    burst_q, burst_d;
    logic [PCW-1:0]    pause_q, pause_d;
    logic              restart_q, restart_d;
    logic [1:0]        mode_q, mode_d;
    logic [23:0]       color_q, color_d;
    logic [31:0]       adr_q, adr_d;
    logic [23:0]       dat_q, dat_d;
    logic              stb_q, stb_d;
    logic              busy_q, busy_d;
    logic              frame_done_q, frame_done_d;

    logic              hs_c;
    logic              last_x_c;
    logic              last_y_c;
    logic              frame_end_c;
    logic              burst_end_c;
    logic              pause_end_c;
    logic              load_c;

    logic [XW-1:0]     nx_x_c;
    logic [YW-1:0]     nx_y_c;
    logic [2:0]        nx_bar_c;
    logic [BNCW-1:0]   nx_bar_cnt_c;

    // Colour-bar palette, left to right
    function automatic logic [23:0] bar_color(input logic [2:0] b);
        logic [23:0] c;
        c = 24'h000000;
        case (b)
            3'd0:    c = 24'hFFFFFF;
            3'd1:    c = 24'hFFFF00;
            3'd2:    c = 24'h00FFFF;
            3'd3:    c = 24'h00FF00;
            3'd4:    c = 24'hFF00FF;
            3'd5:    c = 24'hFF0000;
            3'd6:    c = 24'h0000FF;
            default: c = 24'h000000;
        endcase
        return c;
    endfunction

    // Pattern value for one pixel; bar index comes from the stepping counter
    function automatic logic [23:0] pixel(input logic [1:0]    m,
                                          input logic [23:0]   c,
                                          input logic [XW-1:0] px,
                                          input logic [YW-1:0] py,
                                          input logic [2:0]    b);
        logic [23:0] p;
        p = 24'h000000;
        case (m)
            2'd0:    p = c;
            2'd1:    p = ((px[3:0] == 4'd0) || (py[3:0] == 4'd0)) ? 24'hFFFFFF : 24'h000000;
            2'd2:    p = {px[7:0], px[7:0], px[7:0]};
            default: p = bar_color(b);
        endcase
        return p;
    endfunction

    assign hs_c        = (state_q == S_WRITE) && wb.ack;
    assign last_x_c    = (x_q == XW'(HDISP - 1));
    assign last_y_c    = (y_q == YW'(VDISP - 1));
    assign frame_end_c = hs_c && last_x_c && last_y_c;
    assign burst_end_c = hs_c && (burst_q == BCW'(BURST - 1));
    assign pause_end_c = (pause_q == PCW'(PAUSE - 1));
    assign load_c      = ((state_q == S_IDLE) && start) ||
                         ((state_q == S_PAUSE) && pause_end_c && restart_q);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: frame end wins over burst end
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_WRITE;
            end
            S_WRITE: begin
                if (frame_end_c)      state_d = loop ? S_PAUSE : S_IDLE;
                else if (burst_end_c) state_d = S_PAUSE;
            end
            S_PAUSE: begin
                if (pause_end_c) state_d = S_WRITE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Raster position following the current pixel; bar index steps every BARW pixels
    always_comb begin
        nx_x_c       = x_q + XW'(1);
        nx_y_c       = y_q;
        nx_bar_c     = bar_q;
        nx_bar_cnt_c = bar_cnt_q + BNCW'(1);
        if (last_x_c) begin
            nx_x_c       = '0;
            nx_y_c       = last_y_c ? '0 : (y_q + YW'(1));
            nx_bar_c     = 3'd0;
            nx_bar_cnt_c = '0;
        end else if (bar_cnt_q == BNCW'(BARW - 1)) begin
            nx_bar_cnt_c = '0;
            nx_bar_c     = (bar_q == 3'd7) ? 3'd7 : (bar_q + 3'd1);
        end
    end

    // Outputs and datapath: next pixel is registered on the ack edge
    always_comb begin
        x_d          = x_q;
        y_d          = y_q;
        bar_d        = bar_q;
        bar_cnt_d    = bar_cnt_q;
        burst_d      = burst_q;
        restart_d    = restart_q;
        mode_d       = mode_q;
        color_d      = color_q;
        adr_d        = adr_q;
        dat_d        = dat_q;
        pause_d      = (state_q == S_PAUSE) ? (pause_q + PCW'(1)) : '0;
        stb_d        = (state_d == S_WRITE);
        busy_d       = (state_d != S_IDLE);
        frame_done_d = frame_end_c;

        if (load_c) begin
            mode_d    = mode;
            color_d   = color;
            x_d       = '0;
            y_d       = '0;
            bar_d     = 3'd0;
            bar_cnt_d = '0;
            burst_d   = '0;
            adr_d     = 32'd0;
            restart_d = 1'b0;
            dat_d     = pixel(mode, color, '0, '0, 3'd0);
        end else if (hs_c) begin
            x_d       = nx_x_c;
            y_d       = nx_y_c;
            bar_d     = nx_bar_c;
            bar_cnt_d = nx_bar_cnt_c;
            adr_d     = adr_q + 32'd4;
            dat_d     = pixel(mode_q, color_q, nx_x_c, nx_y_c, nx_bar_c);
            burst_d   = (burst_end_c || frame_end_c) ? '0 : (burst_q + BCW'(1));
            if (frame_end_c) restart_d = loop;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q          <= '0;
            y_q          <= '0;
            bar_q        <= 3'd0;
            bar_cnt_q    <= '0;
            burst_q      <= '0;
            pause_q      <= '0;
            restart_q    <= 1'b0;
            mode_q       <= 2'd0;
            color_q      <= 24'h000000;
            adr_q        <= 32'd0;
            dat_q        <= 24'h000000;
            stb_q        <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            x_q          <= x_d;
            y_q          <= y_d;
            bar_q        <= bar_d;
            bar_cnt_q    <= bar_cnt_d;
            burst_q      <= burst_d;
            pause_q      <= pause_d;
            restart_q    <= restart_d;
            mode_q       <= mode_d;
            color_q      <= color_d;
            adr_q        <= adr_d;
            dat_q        <= dat_d;
            stb_q        <= stb_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign wb.adr     = adr_q;
    assign wb.dat_ms  = {8'h00, dat_q};
    assign wb.we      = 1'b1;
    assign wb.sel     = 4'b1111;
    assign wb.cti     = 3'b000;
    assign wb.bte     = 2'b00;
    assign wb.stb     = stb_q;
    assign wb.cyc     = stb_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_fb_pattern_writer.sv
// Bench for fb_pattern_writer: three instances (small, 32x32, default size),
// one active at a time, checked every cycle against a transaction-level model.
module tb_fb_pattern_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        loop;
    logic [1:0]  mode;
    logic [23:0] color;
    logic        ack;
    logic        ack_rand;
    int          act;

    always #5 clk = ~clk;

    fb_pattern_writer_if wb0 ();
    fb_pattern_writer_if wb1 ();
    fb_pattern_writer_if wb2 ();

    logic rst0, rst1, rst2;
    logic busy0, busy1, busy2;
    logic fd0, fd1, fd2;

    assign rst0    = rst || (act != 0);
    assign rst1    = rst || (act != 1);
    assign rst2    = rst || (act != 2);
    assign wb0.ack = ack && (act == 0);
    assign wb1.ack = ack && (act == 1);
    assign wb2.ack = ack && (act == 2);

    fb_pattern_writer #(.HDISP(8), .VDISP(4), .BURST(5), .PAUSE(2)) u0 (
        .clk(clk), .rst(rst0), .start(start), .loop(loop), .mode(mode),
        .color(color), .busy(busy0), .frame_done(fd0), .wb(wb0.master));

    fb_pattern_writer #(.HDISP(32), .VDISP(32), .BURST(64), .PAUSE(16)) u1 (
        .clk(clk), .rst(rst1), .start(start), .loop(loop), .mode(mode),
        .color(color), .busy(busy1), .frame_done(fd1), .wb(wb1.master));

    fb_pattern_writer u2 (
        .clk(clk), .rst(rst2), .start(start), .loop(loop), .mode(mode),
        .color(color), .busy(busy2), .frame_done(fd2), .wb(wb2.master));

    // Outputs of the instance under test
    logic        a_stb, a_cyc, a_we, a_busy, a_fd;
    logic [31:0] a_adr, a_dat;
    logic [3:0]  a_sel;
    logic [2:0]  a_cti;
    logic [1:0]  a_bte;

    always_comb begin
        case (act)
            1: begin
                a_stb = wb1.stb; a_cyc = wb1.cyc; a_we = wb1.we; a_adr = wb1.adr;
                a_dat = wb1.dat_ms; a_sel = wb1.sel; a_cti = wb1.cti; a_bte = wb1.bte;
                a_busy = busy1; a_fd = fd1;
            end
            2: begin
                a_stb = wb2.stb; a_cyc = wb2.cyc; a_we = wb2.we; a_adr = wb2.adr;
                a_dat = wb2.dat_ms; a_sel = wb2.sel; a_cti = wb2.cti; a_bte = wb2.bte;
                a_busy = busy2; a_fd = fd2;
            end
            default: begin
                a_stb = wb0.stb; a_cyc = wb0.cyc; a_we = wb0.we; a_adr = wb0.adr;
                a_dat = wb0.dat_ms; a_sel = wb0.sel; a_cti = wb0.cti; a_bte = wb0.bte;
                a_busy = busy0; a_fd = fd0;
            end
        endcase
    end

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Model configuration and state
    int          mh, mv, mb, mp;
    bit          m_active, m_restart, m_fd;
    int          m_n, m_gap;
    logic [1:0]  m_mode;
    logic [23:0] m_color;
    int          hs_cnt, fd_cnt, busy_cyc;
    bit          hs_flag;
    logic [31:0] cap_adr [int];
    logic [31:0] cap_dat [int];

    // Expected pixel straight from the pattern definitions (bars by division)
    function automatic logic [31:0] ref_pix(input logic [1:0] md, input logic [23:0] c,
                                            input int x, input int y, input int h);
        int         b;
        logic [7:0] xb;
        xb = 8'(x);
        case (md)
            2'd0: return {8'h00, c};
            2'd1: return ((x % 16 == 0) || (y % 16 == 0)) ? 32'h00FFFFFF : 32'h0;
            2'd2: return {8'h00, xb, xb, xb};
            default: begin
                b = x / (h / 8);
                if (b > 7) b = 7;
                case (b)
                    0: return 32'h00FFFFFF;
                    1: return 32'h00FFFF00;
                    2: return 32'h0000FFFF;
                    3: return 32'h0000FF00;
                    4: return 32'h00FF00FF;
                    5: return 32'h00FF0000;
                    6: return 32'h000000FF;
                    default: return 32'h0;
                endcase
            end
        endcase
    endfunction

    // Per-cycle compare against the model, then advance the model to the next edge
    always @(negedge clk) begin : compare
        bit exp_stb;
        if (rst) begin
            chk("rst_stb", 32'(a_stb), 32'd0);
            chk("rst_cyc", 32'(a_cyc), 32'd0);
            chk("rst_adr", a_adr, 32'd0);
            chk("rst_dat", a_dat, 32'd0);
            chk("rst_busy", 32'(a_busy), 32'd0);
            chk("rst_fd", 32'(a_fd), 32'd0);
            chk("rst_we", 32'(a_we), 32'd1);
            chk("rst_sel", 32'(a_sel), 32'hF);
            m_active = 0; m_restart = 0; m_fd = 0; m_n = 0; m_gap = 0; hs_flag = 0;
        end else begin
            exp_stb = m_active && (m_gap == 0);
            chk("stb", 32'(a_stb), 32'(exp_stb));
            chk("cyc", 32'(a_cyc), 32'(exp_stb));
            chk("busy", 32'(a_busy), 32'(m_active));
            chk("frame_done", 32'(a_fd), 32'(m_fd));
            chk("we", 32'(a_we), 32'd1);
            chk("sel", 32'(a_sel), 32'hF);
            chk("cti_bte", {27'(a_cti), a_bte}, 32'd0);
            if (exp_stb) begin
                chk("adr", a_adr, 32'(4 * m_n));
                chk("dat", a_dat, ref_pix(m_mode, m_color, m_n % mh, m_n / mh, mh));
            end
            if (a_fd)   fd_cnt++;
            if (a_busy) busy_cyc++;

            m_fd    = 0;
            hs_flag = 0;
            if (!m_active) begin
                if (start) begin
                    m_active = 1; m_n = 0; m_gap = 0; m_mode = mode; m_color = color;
                end
            end else if (m_gap > 0) begin
                m_gap--;
                if (m_gap == 0 && m_restart) begin
                    m_restart = 0; m_n = 0; m_mode = mode; m_color = color;
                end
            end else if (ack) begin
                hs_flag = 1;
                cap_adr[m_n] = a_adr;
                cap_dat[m_n] = a_dat;
                hs_cnt++;
                m_n++;
                if (m_n == mh * mv) begin
                    m_fd = 1;
                    if (loop) begin m_gap = mp; m_restart = 1; end
                    else m_active = 0;
                end else if (m_n % mb == 0) begin
                    m_gap = mp;
                end
            end
        end
    end

    // Slave: ack held high, or after a random 0..5 cycle wait per transfer
    int dly = 0;
    always @(posedge clk) begin
        #1;
        if (!ack_rand) begin
            ack = 1'b1;
        end else begin
            if (hs_flag) dly = $urandom_range(0, 5);
            if (dly == 0) ack = 1'b1;
            else begin ack = 1'b0; dly--; end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic clear_counts();
        hs_cnt = 0; fd_cnt = 0; busy_cyc = 0;
        cap_adr.delete();
        cap_dat.delete();
    endtask

    task automatic select(input int k, input int h, input int v, input int b, input int p);
        rst = 1'b1;
        act = k;
        mh = h; mv = v; mb = b; mp = p;
        repeat (3) tick();
        rst = 1'b0;
        repeat (2) tick();
    endtask

    task automatic wait_fd(input int target, input int budget);
        int k;
        k = 0;
        while (fd_cnt < target && k < budget) begin tick(); k++; end
        if (fd_cnt < target) begin
            vectors++; miscompares++;
            $display("FAIL timeout_frame_done: got %0d pulses expected %0d", fd_cnt, target);
        end
    endtask

    task automatic wait_hs(input int target, input int budget);
        int k;
        k = 0;
        while (hs_cnt < target && k < budget) begin tick(); k++; end
        if (hs_cnt < target) begin
            vectors++; miscompares++;
            $display("FAIL timeout_acks: got %0d acks expected %0d", hs_cnt, target);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; loop = 1'b0; mode = 2'd0; color = 24'h0;
        ack_rand = 1'b0; act = 0;

        // Small frame, solid colour, ack held high
        select(0, 8, 4, 5, 2);
        mode = 2'd0; color = 24'h123456;
        clear_counts();
        pulse_start();
        wait_fd(1, 200);
        repeat (3) tick();
        chk("small_writes", 32'(hs_cnt), 32'd32);
        chk("small_last_adr", cap_adr[31], 32'd124);
        chk("small_dat", cap_dat[17], 32'h00123456);
        chk("small_fd_pulses", 32'(fd_cnt), 32'd1);
        chk("small_busy_cycles", 32'(busy_cyc), 32'd44);

        // Looping over two frames, mode changed mid-frame, start while busy
        clear_counts();
        mode = 2'd1; color = 24'($urandom); loop = 1'b1;
        pulse_start();
        wait_hs(10, 100);
        mode = 2'd2; color = 24'($urandom);
        pulse_start();
        wait_fd(1, 300);
        tick();
        loop = 1'b0;
        wait_fd(2, 300);
        repeat (3) tick();
        chk("loop_fd_pulses", 32'(fd_cnt), 32'd2);
        chk("loop_writes", 32'(hs_cnt), 32'd64);
        chk("loop_busy_cycles", 32'(busy_cyc), 32'd90);
        chk("loop_second_mode", cap_dat[1], 32'h00010101);

        // 32x32 grid with random ack delays
        select(1, 32, 32, 64, 16);
        ack_rand = 1'b1; mode = 2'd1; loop = 1'b0;
        clear_counts();
        pulse_start();
        wait_fd(1, 8000);
        repeat (2) tick();
        chk("grid_writes", 32'(hs_cnt), 32'd1024);
        chk("grid_16_5", cap_dat[5 * 32 + 16], 32'h00FFFFFF);
        chk("grid_17_5", cap_dat[5 * 32 + 17], 32'h00000000);
        chk("grid_3_16", cap_dat[16 * 32 + 3], 32'h00FFFFFF);

        // Mid-burst reset drops stb without a clock edge, then a fresh start
        ack_rand = 1'b0; mode = 2'd2;
        clear_counts();
        pulse_start();
        wait_hs(10, 100);
        @(posedge clk);
        #2;
        chk("pre_reset_stb", 32'(a_stb), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("async_reset_stb", 32'(a_stb), 32'd0);
        chk("async_reset_adr", a_adr, 32'd0);
        repeat (2) tick();
        rst = 1'b0;
        repeat (2) tick();
        clear_counts();
        mode = 2'd0; color = 24'hA5C3E1;
        pulse_start();
        wait_hs(3, 50);
        chk("restart_adr0", cap_adr[0], 32'd0);
        chk("restart_dat0", cap_dat[0], 32'h00A5C3E1);

        // Default size, colour bars along the first line
        select(2, 800, 480, 64, 16);
        mode = 2'd3;
        clear_counts();
        pulse_start();
        wait_hs(800, 2000);
        rst = 1'b1;
        tick();
        chk("bars_x0", cap_dat[0], 32'h00FFFFFF);
        chk("bars_x99", cap_dat[99], 32'h00FFFFFF);
        chk("bars_x100", cap_dat[100], 32'h00FFFF00);
        chk("bars_x400", cap_dat[400], 32'h00FF00FF);
        chk("bars_x699", cap_dat[699], 32'h000000FF);
        chk("bars_x799", cap_dat[799], 32'h00000000);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
